// File: rtl/seq_divider_2n_by_n.sv
// Iterative restoring unsigned divider: 2N-bit dividend / N-bit divisor.
// Produces one quotient bit per clock, with valid/ready handshakes on both sides
// and a single operation in flight at a time.
module seq_divider_2n_by_n #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] x,
    input  logic [N-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dbz
);

    localparam int unsigned CntW = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CntW-1:0] LastIter = CntW'(2 * N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic [2*N-1:0]  qreg;     // dividend shifts out the top, quotient bits shift in
    logic [N:0]      rem;      // one extra bit so the shifted value never overflows
    logic [N-1:0]    divisor;
    logic            dbz_lat;

    logic [N:0]      trial;
    logic            fits;
    logic [N:0]      rem_nx;
    logic [2*N-1:0]  qreg_nx;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        trial   = {rem[N-1:0], qreg[2*N-1]};
        fits    = (trial >= {1'b0, divisor});
        rem_nx  = fits ? (trial - {1'b0, divisor}) : trial;
        qreg_nx = {qreg[2*N-2:0], fits};
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dbz       <= 1'b0;
            cnt       <= '0;
            qreg      <= '0;
            rem       <= '0;
            divisor   <= '0;
            dbz_lat   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        divisor  <= y;
                        if (y == '0) begin
                            // Divide by zero: saturate both results, skip iteration.
                            qreg    <= '1;
                            rem     <= '1;
                            dbz_lat <= 1'b1;
                            state   <= StDone;
                        end else begin
                            qreg    <= x;
                            rem     <= '0;
                            dbz_lat <= 1'b0;
                            state   <= StRun;
                        end
                    end
                end
                StRun: begin
                    qreg <= qreg_nx;
                    rem  <= rem_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LastIter) begin
                        // Publish straight from the last step to save a cycle.
                        state     <= StDone;
                        out_valid <= 1'b1;
                        q         <= qreg_nx;
                        r         <= rem_nx[N-1:0];
                        dbz       <= 1'b0;
                    end
                end
                StDone: begin
                    if (!out_valid) begin
                        // Only the divide-by-zero path arrives here unpublished.
                        out_valid <= 1'b1;
                        q         <= qreg;
                        r         <= rem[N-1:0];
                        dbz       <= dbz_lat;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_2n_by_n.sv
// Self-checking bench for seq_divider_2n_by_n (N = 4): directed vector table,
// backpressure, mid-operation reset and an exhaustive sweep of all operands.
module tb_seq_divider_2n_by_n;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] x = '0;
    logic [N-1:0]   y = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dbz;

    seq_divider_2n_by_n #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] vx;
        logic [3:0] vy;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edbz;
        int         elat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic start_op(input logic [7:0] xv, input logic [3:0] yv);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready timeout", 32'd0, 32'd1);
        x        = xv;
        y        = yv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Operands only need to be valid in the accept cycle.
        x = ~xv;
        y = ~yv;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) check("out_valid timeout", 32'd0, 32'd1);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bit seen;
        bit ok;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ed;

        vecs[0] = '{vx: 8'd200, vy: 4'd7,  eq: 8'd28,  er: 4'd4,  edbz: 1'b0, elat: 8};
        vecs[1] = '{vx: 8'd255, vy: 4'd1,  eq: 8'd255, er: 4'd0,  edbz: 1'b0, elat: 8};
        vecs[2] = '{vx: 8'd0,   vy: 4'd5,  eq: 8'd0,   er: 4'd0,  edbz: 1'b0, elat: 8};
        vecs[3] = '{vx: 8'd15,  vy: 4'd15, eq: 8'd1,   er: 4'd0,  edbz: 1'b0, elat: 8};
        vecs[4] = '{vx: 8'd123, vy: 4'd0,  eq: 8'd255, er: 4'd15, edbz: 1'b1, elat: 1};
        vecs[5] = '{vx: 8'd250, vy: 4'd15, eq: 8'd16,  er: 4'd10, edbz: 1'b0, elat: 8};
        vecs[6] = '{vx: 8'd100, vy: 4'd3,  eq: 8'd33,  er: 4'd1,  edbz: 1'b0, elat: 8};
        vecs[7] = '{vx: 8'd14,  vy: 4'd15, eq: 8'd0,   er: 4'd14, edbz: 1'b0, elat: 8};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset q", 32'(q), 32'd0);
        check("reset r", 32'(r), 32'd0);
        check("reset dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        foreach (vecs[i]) begin
            start_op(vecs[i].vx, vecs[i].vy);
            check("busy in_ready", 32'(in_ready), 32'd0);
            wait_result(lat);
            check($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].eq));
            check($sformatf("vec%0d r", i), 32'(r), 32'(vecs[i].er));
            check($sformatf("vec%0d dbz", i), 32'(dbz), 32'(vecs[i].edbz));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].elat));
            handoff();
            check($sformatf("vec%0d idle", i), {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Backpressure: result held, in_valid pulses ignored.
        start_op(8'd200, 4'd7);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold cycle %0d", i), {17'd0, out_valid, in_ready, dbz, r, q},
                  {17'd0, 1'b1, 1'b0, 1'b0, 4'd4, 8'd28});
            x        = 8'd1;
            y        = 4'd1;
            in_valid = (i % 2 == 0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        handoff();
        check("after hold idle", {30'd0, out_valid, in_ready}, 32'd1);
        check("q/r kept in idle", {20'd0, r, q}, {20'd0, 4'd4, 8'd28});
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("no ghost op after hold", 32'(seen), 32'd0);

        // Reset at iteration 4 aborts the operation.
        start_op(8'd200, 4'd7);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort outputs", {17'd0, out_valid, in_ready, dbz, r, q},
              {17'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no result after abort", 32'(seen), 32'd0);
        start_op(8'd99, 4'd9);
        wait_result(lat);
        check("post-abort q", 32'(q), 32'd11);
        check("post-abort r", 32'(r), 32'd0);
        check("post-abort latency", 32'(lat), 32'd8);
        handoff();

        // Exhaustive sweep with random consumer delay.
        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                start_op(8'(xi), 4'(yi));
                wait_result(lat);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (yi == 0) begin
                    eq = 8'hff;
                    er = 4'hf;
                    ed = 1'b1;
                end else begin
                    eq = 8'(xi / yi);
                    er = 4'(xi % yi);
                    ed = 1'b0;
                end
                ok = (q === eq) && (r === er) && (dbz === ed) && out_valid;
                if (yi != 0) ok = ok && (int'(q) * yi + int'(r) == xi) && (int'(r) < yi);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL exhaustive x=%0d y=%0d: got q=%0d r=%0d dbz=%0d expected q=%0d r=%0d dbz=%0d",
                             xi, yi, q, r, dbz, eq, er, ed);
                end
                handoff();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
